// File: rtl/conv_window_engine_pkg.sv
// Shared types and helpers for the K x K sliding-window convolution engine.
package conv_window_engine_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ABS     = 2'b10,
    MODE_SAT_ALT = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_DONE
  } state_t;

  // Index width for n entries, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned coef_idx_w(input int unsigned k);
    return idx_w(k * k);
  endfunction

endpackage

// File: rtl/conv_mac_tree.sv
// Combinational K x K multiply-accumulate, arithmetic shift and pixel conversion.
module conv_mac_tree
  import conv_window_engine_pkg::*;
#(
  parameter int K_SIZE = 5,
  parameter int PIXEL  = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 32,
  parameter int SHIFT  = 0
) (
  input  logic [K_SIZE*K_SIZE-1:0][PIXEL-1:0]  win,
  input  logic [K_SIZE*K_SIZE-1:0][COEF_W-1:0] coef,
  input  mode_t                                mode,
  output logic [PIXEL-1:0]                     pix
);

  localparam logic signed [ACC_W-1:0] PIX_MAX = {{(ACC_W-PIXEL){1'b0}}, {PIXEL{1'b1}}};

  logic signed [ACC_W-1:0]        acc;
  logic signed [ACC_W-1:0]        shifted;
  logic signed [ACC_W-1:0]        mag;
  logic signed [PIXEL+COEF_W:0]   prod;

  function automatic logic [PIXEL-1:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v < 0)            return '0;
    else if (v > PIX_MAX) return '1;
    else                  return v[PIXEL-1:0];
  endfunction

  // NOTE: combinational temporaries use blocking '=' so each loop iteration sees the previous sum.
  always_comb begin
    acc  = '0;
    prod = '0;
    for (int i = 0; i < K_SIZE*K_SIZE; i++) begin
      prod = $signed({1'b0, win[i]}) * $signed(coef[i]);
      acc  = acc + ACC_W'(prod);
    end
  end

  assign shifted = acc >>> SHIFT;
  assign mag     = shifted[ACC_W-1] ? -shifted : shifted;

  always_comb begin
    case (mode)
      MODE_WRAP: pix = shifted[PIXEL-1:0];
      MODE_ABS:  pix = saturate(mag);
      default:   pix = saturate(shifted);
    endcase
  end

endmodule

// File: rtl/conv_window_engine.sv
// Sliding-window convolution engine: frame FSM, column window, coefficient RAM
// and a one-deep output register with ready/valid on both sides.
module conv_window_engine
  import conv_window_engine_pkg::*;
#(
  parameter int K_SIZE   = 5,
  parameter int PIXEL    = 8,
  parameter int COEF_W   = 8,
  parameter int IMG_W    = 512,
  parameter int OUT_ROWS = 508,
  parameter int ACC_W    = 32,
  parameter int SHIFT    = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [1:0]                      mode,
  input  logic                            coef_we,
  input  logic [coef_idx_w(K_SIZE)-1:0]   coef_addr,
  input  logic [COEF_W-1:0]               coef_data,
  input  logic                            col_valid,
  output logic                            col_ready,
  input  logic [K_SIZE*PIXEL-1:0]         col_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [PIXEL-1:0]                pix_out,
  output logic                            busy,
  output logic                            done
);

  localparam int NTAPS = K_SIZE * K_SIZE;
  localparam int CW    = idx_w(IMG_W);
  localparam int RW    = idx_w(OUT_ROWS);

  state_t                         state;
  mode_t                          mode_q;
  logic [NTAPS-1:0][COEF_W-1:0]   coef;
  logic [NTAPS-1:0][PIXEL-1:0]    win;
  logic [NTAPS-1:0][PIXEL-1:0]    win_next;
  logic [CW-1:0]                  col_cnt;
  logic [RW-1:0]                  row_cnt;
  logic                           last_seen;
  logic                           col_fire;
  logic                           out_fire;
  logic                           coef_hit;
  logic [PIXEL-1:0]               mac_pix;

  // Window as it will look once the offered column is shifted in; the MAC works on this.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    win_next = win;
    for (int r = 0; r < K_SIZE; r++) begin
      for (int c = 0; c < K_SIZE; c++) begin
        if (c < K_SIZE-1) win_next[r*K_SIZE+c] = win[r*K_SIZE+c+1];
        else              win_next[r*K_SIZE+c] = col_data[r*PIXEL +: PIXEL];
      end
    end
  end

  assign col_ready = (state == ST_FILL) ||
                     ((state == ST_RUN) && !last_seen && (!out_valid || out_ready));
  assign col_fire  = col_valid && col_ready;
  assign out_fire  = out_valid && out_ready;
  assign coef_hit  = coef_we && (state == ST_IDLE) && (int'(coef_addr) < NTAPS);

  conv_mac_tree #(
    .K_SIZE (K_SIZE),
    .PIXEL  (PIXEL),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W),
    .SHIFT  (SHIFT)
  ) u_mac (
    .win  (win_next),
    .coef (coef),
    .mode (mode_q),
    .pix  (mac_pix)
  );

  // NOTE: the coefficient store is reset on purpose: a reset must leave an all-zero filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_WRAP;
      coef      <= '0;
      win       <= '0;
      col_cnt   <= '0;
      row_cnt   <= '0;
      last_seen <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (coef_hit) coef[coef_addr] <= coef_data;
          if (start) begin
            mode_q    <= mode_t'(mode);
            win       <= '0;
            col_cnt   <= '0;
            row_cnt   <= '0;
            last_seen <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (col_fire) begin
            win     <= win_next;
            col_cnt <= col_cnt + 1'b1;
            if (col_cnt == CW'(K_SIZE-2)) state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (col_fire) begin
            win     <= win_next;
            col_cnt <= col_cnt + 1'b1;
            if (col_cnt == CW'(IMG_W-1)) begin
              col_cnt <= '0;
              win     <= '0;
              if (row_cnt == RW'(OUT_ROWS-1)) begin
                last_seen <= 1'b1;
              end else begin
                row_cnt <= row_cnt + 1'b1;
                state   <= ST_FILL;
              end
            end
          end
          // The final result is pending until downstream takes it.
          if (last_seen && out_fire) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      pix_out   <= '0;
    end else if (col_fire && (state == ST_RUN)) begin
      out_valid <= 1'b1;
      pix_out   <= mac_pix;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_engine.sv
// Scoreboard bench for conv_window_engine: a reference model predicts each
// filtered pixel when its completing column is accepted; outputs are popped in order.
module tb_conv_window_engine;
  import conv_window_engine_pkg::*;

  localparam int K        = 3;
  localparam int PIX      = 8;
  localparam int CWID     = 8;
  localparam int IW       = 8;
  localparam int OR       = 2;
  localparam int AW       = coef_idx_w(K);
  localparam int PER_ROW  = IW - K + 1;
  localparam int TOTAL    = PER_ROW * OR;

  localparam int CK_ID   = 0;
  localparam int CK_BOX  = 1;
  localparam int CK_NEG  = 2;
  localparam int CK_NONE = 3;

  localparam int SIDE_NONE   = 0;
  localparam int SIDE_INJECT = 1;
  localparam int SIDE_STALL  = 2;
  localparam int SIDE_RESET  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [1:0]        mode;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [CWID-1:0]   coef_data;
  logic              col_valid;
  logic              col_ready;
  logic [K*PIX-1:0]  col_data;
  logic              out_valid;
  logic              out_ready;
  logic [PIX-1:0]    pix_out;
  logic              busy;
  logic              done;

  logic              col_ready_s3;
  logic              out_valid_s3;
  logic [PIX-1:0]    pix_s3;
  logic              busy_s3;
  logic              done_s3;

  typedef struct {
    int exp;
    int exp_s3;
  } sb_t;

  sb_t sb_q[$];
  int  coef_m[K*K];
  int  pat;
  int  cur_mode;
  int  out_count;
  int  done_cnt;
  bit  done_due;
  bit  abort;
  int  n_vec;
  int  n_err;

  always #5 clk = ~clk;

  conv_window_engine #(
    .K_SIZE(K), .PIXEL(PIX), .COEF_W(CWID), .IMG_W(IW), .OUT_ROWS(OR), .ACC_W(32), .SHIFT(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .col_valid(col_valid), .col_ready(col_ready), .col_data(col_data),
    .out_valid(out_valid), .out_ready(out_ready), .pix_out(pix_out),
    .busy(busy), .done(done)
  );

  conv_window_engine #(
    .K_SIZE(K), .PIXEL(PIX), .COEF_W(CWID), .IMG_W(IW), .OUT_ROWS(OR), .ACC_W(32), .SHIFT(3)
  ) dut_s3 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .col_valid(col_valid), .col_ready(col_ready_s3), .col_data(col_data),
    .out_valid(out_valid_s3), .out_ready(out_ready), .pix_out(pix_s3),
    .busy(busy_s3), .done(done_s3)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pix_val(input int row, input int col, input int r);
    case (pat)
      0:       return row*100 + 10*col + r;
      1:       return 100;
      default: return 50;
    endcase
  endfunction

  function automatic int clamp(input int v);
    if (v < 0)   return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  // Result of the window whose newest column is `col` of image row `row`.
  function automatic int model(input int row, input int col, input int md, input int sh);
    int acc;
    acc = 0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        acc += pix_val(row, col - (K-1) + c, r) * coef_m[r*K+c];
    acc = acc >>> sh;
    case (md)
      0:       return acc & 255;
      2:       return clamp(acc < 0 ? -acc : acc);
      default: return clamp(acc);
    endcase
  endfunction

  // Output monitor: outputs sampled on the falling edge, a handshake completes on the next rise.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (done_due) begin
        check("done_pulse", int'(done), 1);
        done_due = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out", sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          check("pix", int'(pix_out), e.exp);
          check("pix_s3", int'(pix_s3), e.exp_s3);
        end
        out_count++;
        if (out_count == TOTAL) done_due = 1'b1;
      end
    end
  end

  task automatic write_coef(input int a, input int v);
    coef_we   = 1'b1;
    coef_addr = AW'(a);
    coef_data = CWID'(v);
    @(posedge clk); #1;
    coef_we   = 1'b0;
    if (a < K*K) coef_m[a] = v;
  endtask

  task automatic load_coefs(input int ck);
    for (int i = 0; i < K*K; i++) begin
      case (ck)
        CK_ID:   write_coef(i, (i == 4) ? 1 : 0);
        CK_BOX:  write_coef(i, 1);
        default: write_coef(i, (i == 4) ? -1 : 0);
      endcase
    end
    write_coef(15, 85);
  endtask

  task automatic wait_outs(input int n);
    int t;
    t = 0;
    while (out_count < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (out_count < n) check("wait_outs", out_count, n);
  endtask

  task automatic drive_frame();
    bit accepted;
    sb_t e;
    for (int row = 0; row < OR; row++) begin
      for (int col = 0; col < IW; col++) begin
        if (!abort) begin
          col_valid = 1'b1;
          for (int r = 0; r < K; r++) col_data[r*PIX +: PIX] = PIX'(pix_val(row, col, r));
          accepted = 1'b0;
          for (int t = 0; t < 100 && !accepted && !abort; t++) begin
            @(negedge clk);
            if (!abort && col_ready) begin
              accepted = 1'b1;
              if (col >= K-1) begin
                e.exp    = model(row, col, cur_mode, 0);
                e.exp_s3 = model(row, col, cur_mode, 3);
                sb_q.push_back(e);
              end
            end
            @(posedge clk); #1;
          end
          if (!abort && !accepted) begin
            check("col_accept", int'(accepted), 1);
            abort = 1'b1;
          end
        end
      end
    end
    col_valid = 1'b0;
  endtask

  task automatic side_task(input int side);
    int held;
    held = 0;
    case (side)
      SIDE_INJECT: begin
        wait_outs(2);
        @(posedge clk); #1;
        coef_we = 1'b1; coef_addr = AW'(4); coef_data = 8'd77;
        start   = 1'b1; mode = 2'b00;
        @(posedge clk); #1;
        coef_we = 1'b0; start = 1'b0;
      end
      SIDE_STALL: begin
        wait_outs(3);
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("stall_valid", int'(out_valid), 1);
          check("stall_col_ready", int'(col_ready), 0);
          if (i == 0) held = int'(pix_out);
          else        check("stall_hold", int'(pix_out), held);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
      SIDE_RESET: begin
        wait_outs(PER_ROW + 2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_col_ready", int'(col_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_pix_out", int'(pix_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        abort = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb_q.delete();
        done_due = 1'b0;
        for (int i = 0; i < K*K; i++) coef_m[i] = 0;
      end
      default: ;
    endcase
  endtask

  task automatic run_frame(input int ck, input int md, input int p, input int side);
    int d0;
    int t;
    if (ck != CK_NONE) load_coefs(ck);
    pat       = p;
    cur_mode  = md;
    out_count = 0;
    abort     = 1'b0;
    done_due  = 1'b0;
    d0        = done_cnt;
    mode      = 2'(md);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    check("busy_after_start", int'(busy), 1);
    fork
      drive_frame();
      side_task(side);
    join
    if (side != SIDE_RESET) begin
      t = 0;
      while (busy && t < 200) begin
        @(negedge clk);
        t++;
      end
      check("frame_idle", int'(busy), 0);
      check("out_count", out_count, TOTAL);
      check("done_count", done_cnt - d0, 1);
      check("sb_empty", sb_q.size(), 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0; out_count = 0; done_cnt = 0;
    done_due = 1'b0; abort = 1'b0; pat = 0; cur_mode = 1;
    for (int i = 0; i < K*K; i++) coef_m[i] = 0;
    rst_n = 1'b0; start = 1'b0; mode = 2'b00; coef_we = 1'b0;
    coef_addr = '0; coef_data = '0; col_valid = 1'b0; col_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_col_ready", int'(col_ready), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_pix_out", int'(pix_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame(CK_ID,   1, 0, SIDE_INJECT);  // identity: 11,21,..,61 then row 1
    run_frame(CK_BOX,  1, 1, SIDE_STALL);   // 900 -> 255 (SHIFT=3 build: 112)
    run_frame(CK_BOX,  0, 1, SIDE_NONE);    // 900 mod 256 = 132
    run_frame(CK_BOX,  0, 0, SIDE_NONE);    // gradient box across the row boundary
    run_frame(CK_NEG,  1, 2, SIDE_NONE);    // -50 -> 0
    run_frame(CK_NEG,  2, 2, SIDE_NONE);    // |-50| -> 50
    run_frame(CK_NEG,  0, 2, SIDE_NONE);    // -50 wrapped -> 206
    run_frame(CK_NEG,  3, 2, SIDE_NONE);    // mode 11 behaves as saturate
    run_frame(CK_ID,   1, 0, SIDE_RESET);   // reset in the middle of row 1
    run_frame(CK_NONE, 2, 1, SIDE_NONE);    // coefficients lost: all zero

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv_window_engine.md
Name: conv_window_engine

Overview:
Parametrised K×K sliding-window convolution engine. It consumes one K-pixel image column per handshake from the row-buffer block and produces one filtered pixel per valid window. Relative to the previous window/MAC stage it adds runtime-loadable signed coefficients, ready/valid backpressure on both sides, a programmable output mode (wrap/saturate/abs) with a right-shift, and frame-level start/done control.

Parameters:
K_SIZE, 5, window height and width
PIXEL, 8, pixel width in bits (unsigned)
COEF_W, 8, coefficient width (signed two's complement)
IMG_W, 512, input columns per image row
OUT_ROWS, 508, output rows per frame
ACC_W, 32, accumulator width (signed)
SHIFT, 0, arithmetic right shift applied to the accumulator before output conversion

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  frame start pulse; sampled only in IDLE
mode  in  2  00 wrap, 01 saturate, 10 abs+saturate, 11 same as 01; sampled at start
coef_we  in  1  coefficient write strobe; honoured only in IDLE
coef_addr  in  $clog2(K_SIZE*K_SIZE)  coefficient index = r*K_SIZE+c
coef_data  in  COEF_W  signed coefficient
col_valid  in  1  input column valid
col_ready  out  1  engine accepts a column this cycle
col_data  in  K_SIZE*PIXEL  column; bits [r*PIXEL +: PIXEL] = window row r (0 = top)
out_valid  out  1  pix_out valid
out_ready  in  1  downstream accepts pix_out
pix_out  out  PIXEL  filtered pixel
busy  out  1  high in FILL/RUN/DONE
done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all coefficients=0; window registers=0; col/row counters=0; col_ready=0, out_valid=0, pix_out=0, busy=0, done=0.
- Column handshake: col_valid&col_ready. Output handshake: out_valid&out_ready.
- States:
  - IDLE: col_ready=0. coef_we writes coef[coef_addr]; addresses >= K_SIZE*K_SIZE are ignored. On start: latch mode, clear counters and window, go to FILL. coef_we is ignored outside IDLE.
  - FILL: col_ready=1. Each accepted column shifts into the window at column K_SIZE-1; older columns move toward 0. After K_SIZE-1 columns of the current row, go to RUN.
  - RUN: col_ready = !out_valid | out_ready. An accepted column completes a window. On the next edge, out_valid=1 and pix_out=f(window including that column).
  - DONE: lasts one cycle with done=1, then returns to IDLE.
- MAC: acc = Σ_{r,c} $signed({1'b0,pix[r][c]}) * coef[r*K+c], c=0 being the oldest column. Computed in ACC_W bits, then arithmetically shifted right by SHIFT.
- Output conversion:
  - wrap: acc[PIXEL-1:0]
  - saturate: acc<0 → 0; acc>2^PIXEL-1 → all ones; otherwise acc.
  - abs: |acc|, then saturate.
- Latency: 1 cycle from the accepting column handshake to out_valid.
- Backpressure: pix_out and out_valid hold stable while out_valid&!out_ready. No outputs are dropped or duplicated.
- Row wrap: the column counter counts accepted columns 0..IMG_W-1. On acceptance of column IMG_W-1, the counter clears, the window clears, the row counter increments, and the state returns to FILL. Each row yields IMG_W-K_SIZE+1 outputs.
- Frame end: when the final window's output handshake completes (row OUT_ROWS-1, last column), go to DONE. Columns are not accepted after the final column.
- Simultaneous output handshake and new column in RUN: the new result replaces the old one in the same edge, and out_valid stays 1.
- start while not IDLE is ignored. A start in the DONE cycle is ignored.
- Reset mid-frame: immediate return to reset values. Coefficients are lost and must be reloaded.

Decomposition:
- Shared package: mode encodings (MODE_WRAP, MODE_SAT, MODE_ABS), state encodings, and a coefficient-index width function.
- One sub-module, conv_mac_tree: combinational K×K multiply-accumulate plus shift and output conversion, parametrised identically.
- The top module holds the FSM, counters, window shift registers, coefficient RAM and output register.

Test Plan:
Use K_SIZE=3, IMG_W=8, OUT_ROWS=2, PIXEL=8, COEF_W=8, SHIFT=0.
- Identity: coef[4]=1, others 0, mode 01. Column c carries rows {10c,10c+1,10c+2}. Output n of row 0 = 10(n+1)+1 (11,21,…,61); 6 outputs per row; 12 total; done pulses once, 1 cycle after the 12th handshake.
- Box/overflow: all coefs 1, all pixels 100. mode 01 → 255; mode 00 → 900 mod 256 = 132; SHIFT=3 build, mode 01 → 112.
- Negative: coef[4]=-1, center pixel 50. mode 01 → 0; mode 10 → 50; mode 00 → 206.
- Backpressure: out_ready low for 3 cycles mid-row → col_ready low, and pix_out/out_valid stable for those 3 cycles. Total count is still 12 with no duplicates.
- Control: coef_we in RUN → coefficients unchanged; start in RUN → ignored; rst_n low mid-row 1 → all outputs at reset values the same cycle, and coefficients read as 0 in the next frame (all outputs 0).
- Row boundary: columns continuous with col_valid=1 → no output for the first 2 columns of row 1, and the first row-1 output uses only row-1 columns.
